backlight_ramp: RTL and testbench

- Upstream control stage for the backlight PWM generator.
- Accepts brightness commands decoded from the i8080 command path and ramps the current level toward the commanded target.
- Drives the PWM generator's period input (PWMUpData) and compare input (PWMConData).
- Keeps an internal period counter that mirrors the PWM generator's counter, so compare updates land only on period boundaries and never produce glitched pulses.

---
 rtl/backlight_ramp_pkg.sv | 20 ++
 rtl/bl_period_timer.sv | 34 +++
 rtl/backlight_ramp.sv | 156 +++++++++++++++
 tb/tb_backlight_ramp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/backlight_ramp_pkg.sv
// Shared types and helpers for the backlight brightness ramp controller.
// Holds the ramp state encoding, the default level width and the level-to-compare scaling.
package backlight_ramp_pkg;

   localparam int LEVEL_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_state_e;

   // Full-width product keeps the multiply exact before the shift.
   function automatic logic [63:0] scale_level(input logic [31:0] level,
                                               input logic [31:0] period,
                                               input int          level_width);
      return ({32'd0, level} * {32'd0, period}) >> level_width;
   endfunction

endpackage

// File: rtl/bl_period_timer.sv
// Free-running period counter mirroring the PWM generator: counts 0..Period and wraps.
// PERIOD_END marks the terminal count so upstream updates align to period boundaries.
module bl_period_timer
   import backlight_ramp_pkg::*;
#(
   parameter int PWMWidth = 16,
   parameter int Period   = 1023
) (
   input  logic CLK,
   input  logic nRST,
   output logic PERIOD_END
);

   localparam logic [PWMWidth-1:0] CountLast = PWMWidth'(Period);
   localparam logic [PWMWidth-1:0] CountOne  = PWMWidth'(1);

   logic [PWMWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = (count_q == CountLast) ? '0 : count_q + CountOne;
   end

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign PERIOD_END = (count_q == CountLast);

endmodule

// File: rtl/backlight_ramp.sv
// Brightness ramp controller feeding the backlight PWM generator's period and compare inputs.
// Commands land in a one-deep slot and take effect only on period boundaries to avoid glitches.
module backlight_ramp
   import backlight_ramp_pkg::*;
#(
   parameter int PWMWidth   = 16,
   parameter int LevelWidth = LEVEL_WIDTH_DEF,
   parameter int Period     = 1023,
   parameter int StepDiv    = 4
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic [LevelWidth-1:0] CMD_LEVEL,
   input  logic                  CMD_IMM,
   output logic [PWMWidth-1:0]   PWMUpData,
   output logic [PWMWidth-1:0]   PWMConData,
   output logic                  BL_EN,
   output logic                  RAMP_BUSY,
   output logic                  PERIOD_END
);

   localparam int StepW = (StepDiv > 1) ? $clog2(StepDiv) : 1;
   localparam logic [StepW-1:0]      StepLast = StepW'(StepDiv - 1);
   localparam logic [StepW-1:0]      StepOne  = StepW'(1);
   localparam logic [LevelWidth-1:0] LevelOne = LevelWidth'(1);
   localparam logic [LevelWidth-1:0] LevelMax = '1;

   logic period_end;
   logic cmd_accept;

   logic                  started_q, started_d;
   logic                  pending_q, pending_d;
   logic [LevelWidth-1:0] pend_level_q, pend_level_d;
   logic                  pend_imm_q, pend_imm_d;
   logic [LevelWidth-1:0] level_q, level_d;
   logic [LevelWidth-1:0] target_q, target_d;
   ramp_state_e           state_q, state_d;
   logic [StepW-1:0]      step_q, step_d;
   logic [PWMWidth-1:0]   pwm_up_q, pwm_up_d;
   logic [PWMWidth-1:0]   pwm_con_q, pwm_con_d;
   logic                  bl_en_q, bl_en_d;
   logic                  ramp_busy_q, ramp_busy_d;

   bl_period_timer #(
      .PWMWidth (PWMWidth),
      .Period   (Period)
   ) u_timer (
      .CLK        (CLK),
      .nRST       (nRST),
      .PERIOD_END (period_end)
   );

   // started_q holds READY low for the first cycle out of reset.
   assign CMD_READY  = started_q && !pending_q;
   assign cmd_accept = CMD_VALID && CMD_READY;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      started_d    = 1'b1;
      pending_d    = pending_q;
      pend_level_d = pend_level_q;
      pend_imm_d   = pend_imm_q;
      level_d      = level_q;
      target_d     = target_q;
      state_d      = state_q;
      step_d       = step_q;
      pwm_up_d     = PWMWidth'(Period);
      pwm_con_d    = pwm_con_q;
      bl_en_d      = bl_en_q;

      if (period_end) begin
         if (pending_q) begin
            pending_d = 1'b0;
            target_d  = pend_level_q;
            step_d    = '0;
            if (pend_imm_q) begin
               level_d = pend_level_q;
               state_d = HOLD;
            end else if (pend_level_q > level_q) begin
               state_d = RAMP_UP;
            end else if (pend_level_q < level_q) begin
               state_d = RAMP_DOWN;
            end else begin
               state_d = HOLD;
            end
         end else if (state_q != HOLD) begin
            if (step_q == StepLast) begin
               step_d = '0;
               if (state_q == RAMP_UP && level_q != LevelMax) begin
                  level_d = level_q + LevelOne;
               end else if (state_q == RAMP_DOWN && level_q != '0) begin
                  level_d = level_q - LevelOne;
               end
               if (level_d == target_q) begin
                  state_d = HOLD;
               end
            end else begin
               step_d = step_q + StepOne;
            end
         end

         // Compare and enable follow the level that takes effect from the next count 0.
         pwm_con_d = PWMWidth'(scale_level(32'(level_d), Period, LevelWidth));
         bl_en_d   = (level_d != '0);
      end

      // READY is low whenever a slot is pending, so accept never collides with consume.
      if (cmd_accept) begin
         pending_d    = 1'b1;
         pend_level_d = CMD_LEVEL;
         pend_imm_d   = CMD_IMM;
      end

      ramp_busy_d = (level_d != target_d) || pending_d;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         started_q    <= 1'b0;
         pending_q    <= 1'b0;
         // NOTE: the slot payload is reset as well so no X can ever reach the level path.
         pend_level_q <= '0;
         pend_imm_q   <= 1'b0;
         level_q      <= '0;
         target_q     <= '0;
         state_q      <= HOLD;
         step_q       <= '0;
         pwm_up_q     <= PWMWidth'(Period);
         pwm_con_q    <= '0;
         bl_en_q      <= 1'b0;
         ramp_busy_q  <= 1'b0;
      end else begin
         started_q    <= started_d;
         pending_q    <= pending_d;
         pend_level_q <= pend_level_d;
         pend_imm_q   <= pend_imm_d;
         level_q      <= level_d;
         target_q     <= target_d;
         state_q      <= state_d;
         step_q       <= step_d;
         pwm_up_q     <= pwm_up_d;
         pwm_con_q    <= pwm_con_d;
         bl_en_q      <= bl_en_d;
         ramp_busy_q  <= ramp_busy_d;
      end
   end

   assign PWMUpData  = pwm_up_q;
   assign PWMConData = pwm_con_q;
   assign BL_EN      = bl_en_q;
   assign RAMP_BUSY  = ramp_busy_q;
   assign PERIOD_END = period_end;

endmodule

// File: tb/tb_backlight_ramp.sv
// Directed self-checking bench for backlight_ramp at default parameters (Period 1023, StepDiv 4).
// Expected compare values are floor(level * 1023 / 256).
module tb_backlight_ramp;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_level;
   logic        cmd_imm;
   logic [15:0] pwm_up;
   logic [15:0] pwm_con;
   logic        bl_en;
   logic        ramp_busy;
   logic        period_end;

   int n_checks = 0;
   int n_errors = 0;

   backlight_ramp u_dut (
      .CLK        (clk),
      .nRST       (rst_n),
      .CMD_VALID  (cmd_valid),
      .CMD_READY  (cmd_ready),
      .CMD_LEVEL  (cmd_level),
      .CMD_IMM    (cmd_imm),
      .PWMUpData  (pwm_up),
      .PWMConData (pwm_con),
      .BL_EN      (bl_en),
      .RAMP_BUSY  (ramp_busy),
      .PERIOD_END (period_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, want);
      end
   endtask

   function automatic logic [31:0] exp_con(input int lvl);
      return (lvl * 1023) >> 8;
   endfunction

   // Called at a negedge; returns at the negedge just after the next period-end edge.
   task automatic wait_pe(input string tag);
      int n = 0;
      while (period_end !== 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1100) check({tag, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; holds VALID until accepted, returns at the negedge after acceptance.
   task automatic send_cmd(input logic [7:0] lvl, input logic imm);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_level = lvl;
      cmd_imm   = imm;
      while (cmd_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int          cyc;
      logic        found;
      logic        done;
      logic        bad;
      logic [31:0] prev;
      logic [31:0] maxv;
      int          n;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_level = '0;
      cmd_imm   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_con",   pwm_con, 0);
      check("rst_up",    pwm_up, 1023);
      check("rst_bl_en", bl_en, 0);
      check("rst_busy",  ramp_busy, 0);
      check("rst_ready", cmd_ready, 0);

      // Reset release and first period end.
      rst_n = 1'b1;
      #1 check("ready_before_edge", cmd_ready, 0);
      cyc = 0;
      while (cyc < 3000) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) check("ready_after_edge", cmd_ready, 1);
         if (period_end === 1'b1) break;
      end
      check("pe_first_cycle", cyc, 1023);

      // Immediate 255 accepted on the period-end edge: stored now, applied next period end.
      cmd_valid = 1'b1;
      cmd_level = 8'd255;
      cmd_imm   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("imm_ready_pending", cmd_ready, 0);
      check("imm_busy_pending",  ramp_busy, 1);
      check("imm_con_not_yet",   pwm_con, 0);
      wait_pe("imm");
      check("imm_con",   pwm_con, 1019);
      check("imm_bl_en", bl_en, 1);
      check("imm_busy",  ramp_busy, 0);
      check("imm_ready", cmd_ready, 1);
      repeat (500) @(negedge clk);
      check("imm_con_stable", pwm_con, 1019);

      // Back to 0, then ramp 0 -> 3.
      send_cmd(8'd0, 1'b1);
      wait_pe("zero");
      check("zero_con",   pwm_con, 0);
      check("zero_bl_en", bl_en, 0);
      send_cmd(8'd3, 1'b0);
      for (int k = 1; k <= 13; k++) begin
         wait_pe("ramp3");
         if (k == 1)  check("ramp3_busy_k1", ramp_busy, 1);
         if (k == 4)  check("ramp3_con_k4", pwm_con, 0);
         if (k == 5)  check("ramp3_con_k5", pwm_con, exp_con(1));
         if (k == 5)  check("ramp3_bl_en_k5", bl_en, 1);
         if (k == 8)  check("ramp3_con_k8", pwm_con, exp_con(1));
         if (k == 9)  check("ramp3_con_k9", pwm_con, exp_con(2));
         if (k == 12) check("ramp3_busy_k12", ramp_busy, 1);
         if (k == 13) check("ramp3_con_k13", pwm_con, exp_con(3));
         if (k == 13) check("ramp3_busy_k13", ramp_busy, 0);
      end

      // Second command held while the slot is full.
      send_cmd(8'd100, 1'b1);
      check("pend_ready_low", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_level = 8'd50;
      cmd_imm   = 1'b1;
      n = 0;
      while (period_end !== 1'b1 && n < 1100) begin
         if (cmd_ready !== 1'b0) check("pend_ready_held", cmd_ready, 0);
         @(negedge clk);
         n++;
      end
      check("pend_ready_at_pe", cmd_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("pend_first_con", pwm_con, exp_con(100));
      check("pend_ready_after_pe", cmd_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("pend_second_taken", cmd_ready, 0);
      wait_pe("pend2");
      check("pend_second_con", pwm_con, exp_con(50));

      // Mid-ramp reversal: 0 -> 10, retarget to 2 once level 5 is reached.
      send_cmd(8'd0, 1'b1);
      wait_pe("rev_zero");
      send_cmd(8'd10, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         wait_pe("rev_up");
         if (pwm_con == exp_con(5)) found = 1'b1;
      end
      check("rev_reach5", found, 1);
      send_cmd(8'd2, 1'b0);
      prev = pwm_con;
      maxv = pwm_con;
      bad  = 1'b0;
      done = 1'b0;
      n    = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         wait_pe("rev_down");
         n++;
         if (pwm_con > prev) bad = 1'b1;
         if (pwm_con > maxv) maxv = pwm_con;
         prev = pwm_con;
         if (pwm_con == exp_con(2)) done = 1'b1;
      end
      check("rev_pes",   n, 13);
      check("rev_mono",  bad, 0);
      check("rev_max",   maxv, exp_con(5));
      check("rev_final", pwm_con, exp_con(2));
      check("rev_busy",  ramp_busy, 0);

      // Ramp 1 -> 0: compare and enable drop together.
      send_cmd(8'd1, 1'b1);
      wait_pe("one");
      check("one_con", pwm_con, exp_con(1));
      send_cmd(8'd0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         wait_pe("down0");
         if (k == 4) check("down0_bl_en_k4", bl_en, 1);
         if (k == 5) check("down0_con_k5", pwm_con, 0);
         if (k == 5) check("down0_bl_en_k5", bl_en, 0);
      end

      // Asynchronous reset mid-ramp.
      send_cmd(8'd20, 1'b0);
      for (int k = 1; k <= 5; k++) wait_pe("mid");
      check("mid_con_pre",  pwm_con, exp_con(1));
      check("mid_busy_pre", ramp_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_con",   pwm_con, 0);
      check("arst_bl_en", bl_en, 0);
      check("arst_busy",  ramp_busy, 0);
      check("arst_ready", cmd_ready, 0);
      check("arst_up",    pwm_up, 1023);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
